// File: rtl/frogger_state_ctrl_if.sv
// Frogger game-state bus: frame/button/collision inputs and the registered
// game-state outputs consumed by the frog, car and HUD logic.
interface frogger_state_ctrl_if;
  logic        i_Frame_Tick;
  logic        i_Game_Start;
  logic        i_Collided;
  logic        i_Goal_Reached;
  logic [2:0]  o_State;
  logic        o_Frog_Reset;
  logic        o_Cars_Enable;
  logic [2:0]  o_Level;
  logic [1:0]  o_Lives;
  logic [6:0]  o_Score;
  logic [10:0] o_Time_Left;

  // game side: drives events, observes state
  modport master (
    output i_Frame_Tick, i_Game_Start, i_Collided, i_Goal_Reached,
    input  o_State, o_Frog_Reset, o_Cars_Enable, o_Level, o_Lives,
           o_Score, o_Time_Left
  );

  // controller side
  modport slave (
    input  i_Frame_Tick, i_Game_Start, i_Collided, i_Goal_Reached,
    output o_State, o_Frog_Reset, o_Cars_Enable, o_Level, o_Lives,
           o_Score, o_Time_Left
  );
endinterface

// File: rtl/frogger_state_ctrl.sv
// Frogger game-state controller: IDLE -> PLAYING with death / level-up
// interludes, lives, score, level and per-attempt timer. Every output is a
// register updated one clock after the input cycle that causes it.
module frogger_state_ctrl #(
  parameter int c_LIVES        = 3,
  parameter int c_DEATH_FRAMES = 60,
  parameter int c_LEVEL_FRAMES = 90,
  parameter int c_TIME_FRAMES  = 1800,
  parameter int c_MAX_LEVEL    = 7
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst_L,
  frogger_state_ctrl_if.slave  bus
);

  localparam int CW = 12;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PLAYING   = 3'd1,
    S_DYING     = 3'd2,
    S_LEVEL_UP  = 3'd3,
    S_GAME_OVER = 3'd4
  } state_t;

  localparam logic [1:0]    LIVES_INIT = 2'(c_LIVES);
  localparam logic [10:0]   TIME_INIT  = 11'(c_TIME_FRAMES);
  localparam logic [CW-1:0] DEATH_CNT  = CW'(c_DEATH_FRAMES);
  localparam logic [CW-1:0] LEVEL_CNT  = CW'(c_LEVEL_FRAMES);
  localparam logic [2:0]    LEVEL_MAX  = 3'(c_MAX_LEVEL);
  localparam logic [6:0]    SCORE_MAX  = 7'd99;

  state_t        state;
  logic          frog_reset;
  logic          cars_enable;
  logic [2:0]    level;
  logic [1:0]    lives;
  logic [6:0]    score;
  logic [10:0]   time_left;
  logic [CW-1:0] frame_cnt;

  // Timeout only counts when the timer is already empty on a tick.
  logic timeout;
  assign timeout = bus.i_Frame_Tick && (time_left == 11'd0);

  // Single state machine; all outputs registered alongside the state.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      state       <= S_IDLE;
      frog_reset  <= 1'b0;
      cars_enable <= 1'b0;
      level       <= 3'd0;
      lives       <= 2'd0;
      score       <= 7'd0;
      time_left   <= 11'd0;
      frame_cnt   <= '0;
    end else begin
      frog_reset <= 1'b0;
      case (state)
        S_IDLE, S_GAME_OVER: begin
          // Game-over holds the final score/level/lives until a new start.
          if (bus.i_Game_Start) begin
            lives       <= LIVES_INIT;
            score       <= 7'd0;
            level       <= 3'd0;
            time_left   <= TIME_INIT;
            frog_reset  <= 1'b1;
            cars_enable <= 1'b1;
            state       <= S_PLAYING;
          end
        end
        S_PLAYING: begin
          // Collision beats goal, goal beats timeout.
          if (bus.i_Collided || (!bus.i_Goal_Reached && timeout)) begin
            cars_enable <= 1'b0;
            if (lives > 2'd1) begin
              lives     <= lives - 2'd1;
              frame_cnt <= DEATH_CNT;
              state     <= S_DYING;
            end else begin
              lives     <= 2'd0;
              state     <= S_GAME_OVER;
            end
          end else if (bus.i_Goal_Reached) begin
            cars_enable <= 1'b0;
            if (score < SCORE_MAX) score <= score + 7'd1;
            if (level < LEVEL_MAX) level <= level + 3'd1;
            frame_cnt <= LEVEL_CNT;
            state     <= S_LEVEL_UP;
          end else if (bus.i_Frame_Tick) begin
            time_left <= time_left - 11'd1;
          end
        end
        S_DYING, S_LEVEL_UP: begin
          // Interlude counts frames; collisions, goals and start are ignored.
          // A zero count is treated as expiring so the FSM cannot lock up.
          if (bus.i_Frame_Tick) begin
            if (frame_cnt <= CW'(1)) begin
              frame_cnt   <= '0;
              time_left   <= TIME_INIT;
              frog_reset  <= 1'b1;
              cars_enable <= 1'b1;
              state       <= S_PLAYING;
            end else begin
              frame_cnt <= frame_cnt - CW'(1);
            end
          end
        end
        default: begin
          state       <= S_IDLE;
          cars_enable <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_State       = state;
  assign bus.o_Frog_Reset  = frog_reset;
  assign bus.o_Cars_Enable = cars_enable;
  assign bus.o_Level       = level;
  assign bus.o_Lives       = lives;
  assign bus.o_Score       = score;
  assign bus.o_Time_Left   = time_left;

endmodule

// File: tb/tb_frogger_state_ctrl.sv
// Directed bench: default-parameter controller for the main game flow and a
// short-timer instance for timeout and score saturation.
module tb_frogger_state_ctrl;
  logic i_Clk = 1'b0;
  logic i_Rst_L = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 i_Clk = ~i_Clk;

  frogger_state_ctrl_if bus ();
  frogger_state_ctrl_if bus_t ();

  frogger_state_ctrl dut (.i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .bus(bus.slave));

  frogger_state_ctrl #(
    .c_TIME_FRAMES(4), .c_DEATH_FRAMES(3), .c_LEVEL_FRAMES(2)
  ) dut_t (.i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .bus(bus_t.slave));

  // advance one clock; sample point is 1ns after the rising edge
  task automatic step();
    @(posedge i_Clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_Frame_Tick = 0; bus.i_Game_Start = 0; bus.i_Collided = 0; bus.i_Goal_Reached = 0;
    bus_t.i_Frame_Tick = 0; bus_t.i_Game_Start = 0; bus_t.i_Collided = 0; bus_t.i_Goal_Reached = 0;
  endtask

  // n frame ticks on the selected instance
  task automatic ticks(input int n, input bit t);
    for (int i = 0; i < n; i++) begin
      if (t) bus_t.i_Frame_Tick = 1; else bus.i_Frame_Tick = 1;
      step();
      bus_t.i_Frame_Tick = 0; bus.i_Frame_Tick = 0;
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    i_Rst_L = 0;
    step(); step();
    n_chk++; if (bus.o_State !== 3'd0) begin n_fail++; $display("FAIL reset_state got %0d exp 0", bus.o_State); end
    n_chk++; if (bus.o_Lives !== 2'd0 || bus.o_Score !== 7'd0 || bus.o_Level !== 3'd0) begin
      n_fail++; $display("FAIL reset_counts got lives %0d score %0d level %0d exp 0/0/0", bus.o_Lives, bus.o_Score, bus.o_Level); end
    n_chk++; if (bus.o_Time_Left !== 11'd0 || bus.o_Frog_Reset !== 1'b0 || bus.o_Cars_Enable !== 1'b0) begin
      n_fail++; $display("FAIL reset_outs got time %0d frog %b cars %b exp 0/0/0", bus.o_Time_Left, bus.o_Frog_Reset, bus.o_Cars_Enable); end
    i_Rst_L = 1;
    step();
    n_chk++; if (bus.o_State !== 3'd0) begin n_fail++; $display("FAIL idle_hold got %0d exp 0", bus.o_State); end
  endtask

  task automatic test_start();
    bus.i_Game_Start = 1; step(); bus.i_Game_Start = 0;
    n_chk++; if (bus.o_State !== 3'd1 || bus.o_Lives !== 2'd3 || bus.o_Score !== 7'd0) begin
      n_fail++; $display("FAIL start_load got state %0d lives %0d score %0d exp 1/3/0", bus.o_State, bus.o_Lives, bus.o_Score); end
    n_chk++; if (bus.o_Time_Left !== 11'd1800 || bus.o_Frog_Reset !== 1'b1 || bus.o_Cars_Enable !== 1'b1) begin
      n_fail++; $display("FAIL start_outs got time %0d frog %b cars %b exp 1800/1/1", bus.o_Time_Left, bus.o_Frog_Reset, bus.o_Cars_Enable); end
    step();
    n_chk++; if (bus.o_Frog_Reset !== 1'b0) begin n_fail++; $display("FAIL start_pulse_width got %b exp 0", bus.o_Frog_Reset); end
    ticks(3, 0);
    n_chk++; if (bus.o_Time_Left !== 11'd1797) begin n_fail++; $display("FAIL tick_dec got %0d exp 1797", bus.o_Time_Left); end
    // start ignored while playing
    bus.i_Game_Start = 1; step(); bus.i_Game_Start = 0;
    n_chk++; if (bus.o_Time_Left !== 11'd1797 || bus.o_Frog_Reset !== 1'b0) begin
      n_fail++; $display("FAIL start_ignored got time %0d frog %b exp 1797/0", bus.o_Time_Left, bus.o_Frog_Reset); end
  endtask

  task automatic test_collision();
    bus.i_Collided = 1; step();
    n_chk++; if (bus.o_State !== 3'd2 || bus.o_Lives !== 2'd2 || bus.o_Cars_Enable !== 1'b0) begin
      n_fail++; $display("FAIL collide got state %0d lives %0d cars %b exp 2/2/0", bus.o_State, bus.o_Lives, bus.o_Cars_Enable); end
    // collision still asserted and start pulsed while dying: ignored
    bus.i_Game_Start = 1; step(); bus.i_Game_Start = 0; step(); bus.i_Collided = 0;
    n_chk++; if (bus.o_State !== 3'd2 || bus.o_Lives !== 2'd2) begin
      n_fail++; $display("FAIL dying_ignore got state %0d lives %0d exp 2/2", bus.o_State, bus.o_Lives); end
    ticks(59, 0);
    n_chk++; if (bus.o_State !== 3'd2 || bus.o_Frog_Reset !== 1'b0) begin
      n_fail++; $display("FAIL dying_59 got state %0d frog %b exp 2/0", bus.o_State, bus.o_Frog_Reset); end
    ticks(1, 0);
    n_chk++; if (bus.o_State !== 3'd1 || bus.o_Frog_Reset !== 1'b1 || bus.o_Time_Left !== 11'd1800) begin
      n_fail++; $display("FAIL dying_end got state %0d frog %b time %0d exp 1/1/1800", bus.o_State, bus.o_Frog_Reset, bus.o_Time_Left); end
    step();
    n_chk++; if (bus.o_Frog_Reset !== 1'b0 || bus.o_Cars_Enable !== 1'b1) begin
      n_fail++; $display("FAIL respawn_pulse got frog %b cars %b exp 0/1", bus.o_Frog_Reset, bus.o_Cars_Enable); end
  endtask

  task automatic test_both_events();
    bus.i_Collided = 1; bus.i_Goal_Reached = 1; step();
    bus.i_Collided = 0; bus.i_Goal_Reached = 0;
    n_chk++; if (bus.o_State !== 3'd2 || bus.o_Score !== 7'd0 || bus.o_Lives !== 2'd1 || bus.o_Level !== 3'd0) begin
      n_fail++; $display("FAIL collide_beats_goal got state %0d score %0d lives %0d level %0d exp 2/0/1/0",
                         bus.o_State, bus.o_Score, bus.o_Lives, bus.o_Level); end
    ticks(60, 0);
    n_chk++; if (bus.o_State !== 3'd1) begin n_fail++; $display("FAIL both_respawn got %0d exp 1", bus.o_State); end
  endtask

  task automatic test_goals();
    for (int g = 1; g <= 8; g++) begin
      bus.i_Goal_Reached = 1; step(); bus.i_Goal_Reached = 0;
      n_chk++; if (bus.o_State !== 3'd3 || bus.o_Score !== 7'(g) || bus.o_Level !== 3'((g > 7) ? 7 : g)) begin
        n_fail++; $display("FAIL goal_%0d got state %0d score %0d level %0d exp 3/%0d/%0d",
                           g, bus.o_State, bus.o_Score, bus.o_Level, g, (g > 7) ? 7 : g); end
      ticks(89, 0);
      n_chk++; if (bus.o_State !== 3'd3) begin n_fail++; $display("FAIL levelup_hold_%0d got %0d exp 3", g, bus.o_State); end
      ticks(1, 0);
      n_chk++; if (bus.o_State !== 3'd1 || bus.o_Frog_Reset !== 1'b1) begin
        n_fail++; $display("FAIL levelup_end_%0d got state %0d frog %b exp 1/1", g, bus.o_State, bus.o_Frog_Reset); end
    end
  endtask

  task automatic test_game_over();
    bus.i_Collided = 1; step(); bus.i_Collided = 0;
    n_chk++; if (bus.o_State !== 3'd4 || bus.o_Lives !== 2'd0 || bus.o_Score !== 7'd8 || bus.o_Level !== 3'd7) begin
      n_fail++; $display("FAIL game_over got state %0d lives %0d score %0d level %0d exp 4/0/8/7",
                         bus.o_State, bus.o_Lives, bus.o_Score, bus.o_Level); end
    ticks(5, 0);
    n_chk++; if (bus.o_State !== 3'd4 || bus.o_Score !== 7'd8) begin
      n_fail++; $display("FAIL game_over_hold got state %0d score %0d exp 4/8", bus.o_State, bus.o_Score); end
    bus.i_Game_Start = 1; step(); bus.i_Game_Start = 0;
    n_chk++; if (bus.o_State !== 3'd1 || bus.o_Lives !== 2'd3 || bus.o_Score !== 7'd0 || bus.o_Level !== 3'd0 || bus.o_Frog_Reset !== 1'b1) begin
      n_fail++; $display("FAIL restart got state %0d lives %0d score %0d level %0d frog %b exp 1/3/0/0/1",
                         bus.o_State, bus.o_Lives, bus.o_Score, bus.o_Level, bus.o_Frog_Reset); end
  endtask

  task automatic test_reset_mid_levelup();
    bus.i_Goal_Reached = 1; step(); bus.i_Goal_Reached = 0;
    ticks(89, 0);
    // last tick coincides with reset: reset wins, no respawn pulse
    bus.i_Frame_Tick = 1; i_Rst_L = 0; step(); bus.i_Frame_Tick = 0;
    n_chk++; if (bus.o_State !== 3'd0 || bus.o_Frog_Reset !== 1'b0 || bus.o_Level !== 3'd0 || bus.o_Score !== 7'd0) begin
      n_fail++; $display("FAIL reset_mid got state %0d frog %b level %0d score %0d exp 0/0/0/0",
                         bus.o_State, bus.o_Frog_Reset, bus.o_Level, bus.o_Score); end
    i_Rst_L = 1;
    ticks(3, 0);
    n_chk++; if (bus.o_State !== 3'd0 || bus.o_Frog_Reset !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_after got state %0d frog %b exp 0/0", bus.o_State, bus.o_Frog_Reset); end
  endtask

  task automatic test_timeout();
    bus_t.i_Game_Start = 1; step(); bus_t.i_Game_Start = 0;
    n_chk++; if (bus_t.o_Time_Left !== 11'd4) begin n_fail++; $display("FAIL t_start got %0d exp 4", bus_t.o_Time_Left); end
    ticks(4, 1);
    n_chk++; if (bus_t.o_State !== 3'd1 || bus_t.o_Time_Left !== 11'd0) begin
      n_fail++; $display("FAIL t_zero got state %0d time %0d exp 1/0", bus_t.o_State, bus_t.o_Time_Left); end
    ticks(1, 1);
    n_chk++; if (bus_t.o_State !== 3'd2 || bus_t.o_Lives !== 2'd2) begin
      n_fail++; $display("FAIL t_timeout got state %0d lives %0d exp 2/2", bus_t.o_State, bus_t.o_Lives); end
    ticks(3, 1);
    n_chk++; if (bus_t.o_State !== 3'd1 || bus_t.o_Time_Left !== 11'd4) begin
      n_fail++; $display("FAIL t_respawn got state %0d time %0d exp 1/4", bus_t.o_State, bus_t.o_Time_Left); end
  endtask

  task automatic test_score_saturation();
    // goal on the timeout tick: goal wins over timeout
    ticks(4, 1);
    bus_t.i_Goal_Reached = 1; bus_t.i_Frame_Tick = 1; step();
    bus_t.i_Goal_Reached = 0; bus_t.i_Frame_Tick = 0;
    n_chk++; if (bus_t.o_State !== 3'd3 || bus_t.o_Score !== 7'd1 || bus_t.o_Lives !== 2'd2) begin
      n_fail++; $display("FAIL t_goal_over_timeout got state %0d score %0d lives %0d exp 3/1/2",
                         bus_t.o_State, bus_t.o_Score, bus_t.o_Lives); end
    ticks(2, 1);
    for (int g = 2; g <= 99; g++) begin
      bus_t.i_Goal_Reached = 1; step(); bus_t.i_Goal_Reached = 0;
      ticks(2, 1);
    end
    n_chk++; if (bus_t.o_Score !== 7'd99 || bus_t.o_Level !== 3'd7 || bus_t.o_State !== 3'd1) begin
      n_fail++; $display("FAIL t_score99 got score %0d level %0d state %0d exp 99/7/1", bus_t.o_Score, bus_t.o_Level, bus_t.o_State); end
    bus_t.i_Goal_Reached = 1; step(); bus_t.i_Goal_Reached = 0;
    n_chk++; if (bus_t.o_Score !== 7'd99 || bus_t.o_State !== 3'd3) begin
      n_fail++; $display("FAIL t_score_sat got score %0d state %0d exp 99/3", bus_t.o_Score, bus_t.o_State); end
  endtask

  initial begin
    test_reset();
    test_start();
    test_collision();
    test_both_events();
    test_goals();
    test_game_over();
    test_reset_mid_levelup();
    test_timeout();
    test_score_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/frogger_state_ctrl.md
FROGGER_STATE_CTRL -- requirements
Module: frogger_state_ctrl

Interface
REQ-001 Parameter c_LIVES, default 3: lives loaded at game start (1..3).
REQ-002 Parameter c_DEATH_FRAMES, default 60: frames spent in DYING.
REQ-003 Parameter c_LEVEL_FRAMES, default 90: frames spent in LEVEL_UP.
REQ-004 Parameter c_TIME_FRAMES, default 1800: per-attempt time limit, in frames (max 2047).
REQ-005 Parameter c_MAX_LEVEL, default 7: saturation value of o_Level.
REQ-006 i_Clk  in  1: single system clock; all logic on its rising edge.
REQ-007 i_Rst_L  in  1: synchronous, active-low reset.
REQ-008 i_Frame_Tick  in  1: one-cycle pulse per video frame.
REQ-009 i_Game_Start  in  1: one-cycle start-button pulse, already debounced.
REQ-010 i_Collided  in  1: frog overlaps a car this cycle (level).
REQ-011 i_Goal_Reached  in  1: frog is on a lily-pad tile this cycle (level).
REQ-012 o_State  out  3: IDLE=0, PLAYING=1, DYING=2, LEVEL_UP=3, GAME_OVER=4.
REQ-013 o_Frog_Reset  out  1: one-cycle pulse returning the frog to the start tile.
REQ-014 o_Cars_Enable  out  1: high only in PLAYING; gates car motion.
REQ-015 o_Level  out  3: current level, drives car speed selection.
REQ-016 o_Lives  out  2: remaining lives.
REQ-017 o_Score  out  7: goals reached, binary 0..99.
REQ-018 o_Time_Left  out  11: remaining frames of the current attempt.

Function
REQ-019 All outputs SHALL be registered; every response SHALL appear on the clock edge after the qualifying input cycle (latency 1).
REQ-020 IDLE: on i_Game_Start, load lives=c_LIVES, score=0, level=0, time=c_TIME_FRAMES, pulse o_Frog_Reset, go PLAYING.
REQ-021 PLAYING: on each i_Frame_Tick, o_Time_Left SHALL decrement by 1, never below 0.
REQ-022 PLAYING event priority SHALL be collision > goal > timeout; timeout means o_Time_Left==0 and i_Frame_Tick high.
REQ-023 Collision or timeout with lives>1: decrement lives, load frame counter=c_DEATH_FRAMES, go DYING.
REQ-024 Collision or timeout with lives==1: set lives=0, go GAME_OVER.
REQ-025 Goal: score+1, saturating at 99; level+1, saturating at c_MAX_LEVEL; load frame counter=c_LEVEL_FRAMES; go LEVEL_UP.
REQ-026 DYING and LEVEL_UP: decrement the frame counter on i_Frame_Tick; on a tick with counter==1, reload time=c_TIME_FRAMES, pulse o_Frog_Reset, go PLAYING.
REQ-027 In DYING and LEVEL_UP, i_Collided and i_Goal_Reached SHALL be ignored.
REQ-028 GAME_OVER: hold score, level and lives; on i_Game_Start, perform the REQ-020 load and go PLAYING.
REQ-029 i_Game_Start SHALL be ignored in PLAYING, DYING and LEVEL_UP.
REQ-030 o_Frog_Reset SHALL be exactly one cycle wide per entry into PLAYING.
REQ-031 Undefined o_State encodings SHALL return to IDLE on the next edge.

Reset
REQ-032 i_Rst_L low at a clock edge SHALL force IDLE, o_Frog_Reset=0, o_Cars_Enable=0, o_Level=0, o_Lives=0, o_Score=0, o_Time_Left=0, frame counter=0.
REQ-033 Reset mid-DYING or mid-LEVEL_UP SHALL abort the sequence with no o_Frog_Reset pulse.

Verification
REQ-034 Reset, then i_Game_Start -> next cycle: o_State=1, o_Lives=3, o_Score=0, o_Time_Left=1800, o_Frog_Reset=1 for one cycle.
REQ-035 i_Collided in PLAYING -> o_State=2, o_Lives=2, o_Cars_Enable=0; after 60 ticks -> o_State=1 with an o_Frog_Reset pulse.
REQ-036 i_Collided and i_Goal_Reached in the same cycle -> DYING, score unchanged.
REQ-037 Eight goals -> o_Level=7 (saturated), o_Score=8; score forced to 99 plus one goal -> stays 99.
REQ-038 Three collisions -> GAME_OVER, o_Lives=0; i_Game_Start -> PLAYING, o_Lives=3, o_Score=0.
REQ-039 c_TIME_FRAMES=4, no events -> after 5 ticks -> DYING, o_Lives=2.
